decodificador_instrucao: RTL and testbench



---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/contador_ciclos.sv | 33 +++
 rtl/decodificador_instrucao.sv | 116 +++++++++++
 tb/tb_decodificador_instrucao.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction decoder: field positions, opcodes,
// FSM encoding and the word-splitting helper.
package cpu_pkg;

  localparam int OPC_HI   = 17;
  localparam int OPC_LO   = 15;
  localparam int DEST_HI  = 14;
  localparam int DEST_LO  = 11;
  localparam int A1_HI    = 10;
  localparam int A1_LO    = 7;
  localparam int SIMM_BIT = 6;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;
  localparam int A2_HI    = 3;
  localparam int A2_LO    = 0;

  // Width of the shared dwell-time down-counter.
  localparam int CTR_W = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [3:0] dest;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic       sinal_imm;
    logic [5:0] imm;
  } fields_t;

  // addr2 aliases the low nibble of the immediate; the ALU picks one via sinalImm.
  function automatic fields_t split_instr(input logic [17:0] w);
    fields_t f;
    f.opcode    = w[OPC_HI:OPC_LO];
    f.dest      = w[DEST_HI:DEST_LO];
    f.addr1     = w[A1_HI:A1_LO];
    f.addr2     = w[A2_HI:A2_LO];
    f.sinal_imm = w[SIMM_BIT];
    f.imm       = w[IMM_HI:IMM_LO];
    return f;
  endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Loadable down-counter with zero flag; parks at zero once it gets there.
module contador_ciclos #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decodificador_instrucao.sv
// Issue/control stage: accepts an instruction word, holds its fields for the
// ALU, sequences the register-file write enable and counts retirements.
module decodificador_instrucao
  import cpu_pkg::*;
#(
  parameter int INSTR_W      = 18,
  parameter int EXEC_CYCLES  = 1,
  parameter int WRITE_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [2:0]         opcode,
  output logic [3:0]         addr1,
  output logic [3:0]         addr2,
  output logic [3:0]         dest,
  output logic               sinalImm,
  output logic [5:0]         Imm,
  output logic               we,
  output logic               busy,
  output logic               retired,
  output logic [CNT_W-1:0]   retired_count,
  output state_t             state_o
);

  // Handshake: a word transfers on a posedge where instr_valid && instr_ready;
  // instr_ready is high only in IDLE outside reset, and the upstream must hold
  // instr stable while instr_valid is high and not yet accepted.

  state_t           state_q, state_d;
  fields_t          fields_q, fields_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic             ctr_load;
  logic [CTR_W-1:0] ctr_val;
  logic             ctr_zero;

  contador_ciclos #(.W(CTR_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ctr_load),
    .val_i  (ctr_val),
    .zero_o (ctr_zero)
  );

  always_comb begin
    state_d         = state_q;
    fields_d        = fields_q;
    retired_count_d = retired_count_q;
    ctr_load        = 1'b0;
    ctr_val         = '0;
    we              = 1'b0;
    retired         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          fields_d = split_instr(instr);
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        state_d  = ST_EXEC;
        ctr_load = 1'b1;
        ctr_val  = CTR_W'(EXEC_CYCLES - 1);
      end
      ST_EXEC: begin
        if (ctr_zero) begin
          if (fields_q.opcode == OP_NOP) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_WRITE;
            ctr_load = 1'b1;
            ctr_val  = CTR_W'(WRITE_CYCLES - 1);
          end
        end
      end
      ST_WRITE: begin
        we = 1'b1;
        if (ctr_zero) state_d = ST_DONE;
      end
      ST_DONE: begin
        retired         = 1'b1;
        retired_count_d = retired_count_q + CNT_W'(1);
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset overrides everything, so an in-flight instruction never retires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      fields_q        <= '0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      fields_q        <= fields_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign instr_ready   = (state_q == ST_IDLE) && rst_n;
  assign busy          = (state_q != ST_IDLE);
  assign opcode        = fields_q.opcode;
  assign addr1         = fields_q.addr1;
  assign addr2         = fields_q.addr2;
  assign dest          = fields_q.dest;
  assign sinalImm      = fields_q.sinal_imm;
  assign Imm           = fields_q.imm;
  assign retired_count = retired_count_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_decodificador_instrucao.sv
// Directed bench for decodificador_instrucao: vector table, back-to-back
// stream, counter wrap on a narrow-counter instance and reset during WRITE.
module tb_decodificador_instrucao;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [17:0] instr;
  logic        instr_valid;

  logic        instr_ready, we, busy, retired, sinal_imm;
  logic [2:0]  opcode;
  logic [3:0]  addr1, addr2, dest;
  logic [5:0]  imm;
  logic [15:0] retired_count;
  state_t      state;

  logic        instr_ready_w, we_w, busy_w, retired_w, sinal_imm_w;
  logic [2:0]  opcode_w;
  logic [3:0]  addr1_w, addr2_w, dest_w;
  logic [5:0]  imm_w;
  logic [2:0]  retired_count_w;
  state_t      state_w;

  decodificador_instrucao dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .addr1(addr1), .addr2(addr2),
    .dest(dest), .sinalImm(sinal_imm), .Imm(imm), .we(we), .busy(busy),
    .retired(retired), .retired_count(retired_count), .state_o(state)
  );

  // Narrow-counter twin: sees the same stimulus, lets the wrap be reached quickly.
  decodificador_instrucao #(.CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready_w), .opcode(opcode_w), .addr1(addr1_w), .addr2(addr2_w),
    .dest(dest_w), .sinalImm(sinal_imm_w), .Imm(imm_w), .we(we_w), .busy(busy_w),
    .retired(retired_w), .retired_count(retired_count_w), .state_o(state_w)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int exp_count = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [17:0] instr;
    logic [2:0]  op;
    logic [3:0]  dest;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic        simm;
    logic [5:0]  imm;
    logic        wr;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("wait_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic check_fields(input string tag, input vec_t v);
    chk({tag, "_opcode"}, {29'd0, opcode}, {29'd0, v.op});
    chk({tag, "_dest"},   {28'd0, dest},   {28'd0, v.dest});
    chk({tag, "_addr1"},  {28'd0, addr1},  {28'd0, v.a1});
    chk({tag, "_addr2"},  {28'd0, addr2},  {28'd0, v.a2});
    chk({tag, "_simm"},   {31'd0, sinal_imm}, {31'd0, v.simm});
    chk({tag, "_imm"},    {26'd0, imm},    {26'd0, v.imm});
  endtask

  // Issue one word, then walk the cycles after the accept edge (k=1 is DECODE).
  task automatic run_vec(input vec_t v);
    int len;
    len = v.wr ? 6 : 4;
    wait_ready();
    instr       = v.instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 18'($urandom);
    check_fields("accept", v);
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(negedge clk);
      chk("we",      {31'd0, we},      {31'd0, (v.wr && (k == 3 || k == 4))});
      chk("retired", {31'd0, retired}, {31'd0, (k == len - 1)});
      chk("busy",    {31'd0, busy},    {31'd0, (k < len)});
      chk("ready",   {31'd0, instr_ready}, {31'd0, (k == len)});
    end
    exp_count++;
    exp_q.push_back(16'(exp_count));
    chk("count",   {16'd0, retired_count}, {16'd0, exp_q.pop_front()});
    chk("count_w", {29'd0, retired_count_w}, 32'(exp_count % 8));
    check_fields("held", v);
  endtask

  task automatic do_reset(input int cycles);
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n       = 1'b1;
    exp_count   = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t words[4];
    int cyc, last, nacc, nret, idx;
    bit pend;

    vecs[0] = '{18'b001_0101_0011_0_000010, 3'd1, 4'h5, 4'h3, 4'h2, 1'b0, 6'h02, 1'b1};
    vecs[1] = '{18'b010_1010_0110_1_111111, 3'd2, 4'hA, 4'h6, 4'hF, 1'b1, 6'h3F, 1'b1};
    vecs[2] = '{18'b000_1111_1111_1_101010, 3'd0, 4'hF, 4'hF, 4'hA, 1'b1, 6'h2A, 1'b0};
    vecs[3] = '{18'b111_0000_1001_0_010101, 3'd7, 4'h0, 4'h9, 4'h5, 1'b0, 6'h15, 1'b1};
    vecs[4] = '{18'b100_1100_0001_1_000000, 3'd4, 4'hC, 4'h1, 4'h0, 1'b1, 6'h00, 1'b1};
    vecs[5] = '{18'b000_0001_0010_0_110011, 3'd0, 4'h1, 4'h2, 4'h3, 1'b0, 6'h33, 1'b0};

    // Reset held 3 cycles with a valid word present.
    rst_n       = 1'b0;
    instr       = 18'h3FFFF;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_opcode",  {29'd0, opcode}, 32'd0);
      chk("rst_dest",    {28'd0, dest}, 32'd0);
      chk("rst_imm",     {26'd0, imm}, 32'd0);
      chk("rst_we",      {31'd0, we}, 32'd0);
      chk("rst_retired", {31'd0, retired}, 32'd0);
      chk("rst_count",   {16'd0, retired_count}, 32'd0);
      chk("rst_ready",   {31'd0, instr_ready}, 32'd0);
      chk("rst_state",   {29'd0, state}, {29'd0, ST_IDLE});
    end
    rst_n       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("post_rst_busy",  {31'd0, busy}, 32'd0);

    // Vector table.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Idle with no valid: nothing moves.
    repeat (5) @(negedge clk);
    chk("idle_state", {29'd0, state}, {29'd0, ST_IDLE});
    chk("idle_count", {16'd0, retired_count}, 32'(exp_count));
    check_fields("idle", vecs[5]);

    // Back-to-back: valid held high across four write words.
    words[0] = vecs[0];
    words[1] = vecs[1];
    words[2] = vecs[3];
    words[3] = vecs[4];
    cyc = 0; last = 0; nacc = 0; nret = 0; idx = 0; pend = 1'b0;
    wait_ready();
    instr       = words[0].instr;
    instr_valid = 1'b1;
    while (cyc < 40) begin
      if (pend) begin
        chk("b2b_opcode", {29'd0, opcode}, {29'd0, words[idx].op});
        chk("b2b_dest",   {28'd0, dest},   {28'd0, words[idx].dest});
        idx++;
        if (idx < 4) instr = words[idx].instr;
        else instr_valid = 1'b0;
        pend = 1'b0;
      end
      if (retired) nret++;
      if (instr_ready && instr_valid) begin
        if (nacc > 0) chk("b2b_gap", 32'(cyc - last), 32'd6);
        last = cyc;
        nacc++;
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    exp_count += 4;
    chk("b2b_accepts", 32'(nacc), 32'd4);
    chk("b2b_retired", 32'(nret), 32'd4);
    chk("b2b_count",   {16'd0, retired_count}, 32'(exp_count));

    // Counter wrap on the 3-bit twin (7 -> 0), main counter keeps going.
    do_reset(2);
    @(negedge clk);
    for (int i = 0; i < 9; i++) run_vec(vecs[2]);
    chk("wrap_count_w", {29'd0, retired_count_w}, 32'd1);
    chk("wrap_count",   {16'd0, retired_count}, 32'd9);

    // Reset asserted while WRITE is active.
    wait_ready();
    instr       = vecs[0].instr;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_we_before", {31'd0, we}, 32'd1);
    chk("mid_state_before", {29'd0, state}, {29'd0, ST_WRITE});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_we_after",   {31'd0, we}, 32'd0);
    chk("mid_state_after", {29'd0, state}, {29'd0, ST_IDLE});
    chk("mid_count",      {16'd0, retired_count}, 32'd0);
    chk("mid_retired",    {31'd0, retired}, 32'd0);
    rst_n     = 1'b1;
    exp_count = 0;
    repeat (4) @(negedge clk);
    chk("mid_no_retire", {16'd0, retired_count}, 32'd0);
    chk("mid_we_quiet",  {31'd0, we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
